// File: rtl/rap_reset_sequencer_if.sv
// Control/status bundle between the LA/Wishbone side (master) and the reset sequencer (slave).
interface rap_reset_sequencer_if #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CNT_WIDTH = 14
);
    logic                 rstb_req;
    logic                 sw_reset;
    logic                 fault_i;
    logic [CHANNELS-1:0]  chan_en;
    logic [CHANNELS-1:0]  resetn_o;
    logic [CNT_WIDTH-1:0] count_o;
    logic                 busy;
    logic                 done;
    logic                 fault_seen;

    modport master (
        output rstb_req, sw_reset, fault_i, chan_en,
        input  resetn_o, count_o, busy, done, fault_seen
    );

    modport slave (
        input  rstb_req, sw_reset, fault_i, chan_en,
        output resetn_o, count_o, busy, done, fault_seen
    );
endinterface

// File: rtl/rap_reset_sequencer.sv
// Multi-channel reset tree: stretch, then staggered release of enabled channels.
// Fault and software restart re-hold every channel and rerun the full sequence.
module rap_reset_sequencer #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CNT_WIDTH = 14,
  parameter int unsigned STAGGER   = 16
) (
    input logic                   wb_clk_i,
    input logic                   wb_rst_i,
    rap_reset_sequencer_if.slave  bus
);
    localparam int unsigned IdxW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned StagW = $clog2(STAGGER + 1);

    typedef enum logic [1:0] {StIdle, StStretch, StRelease, StRun} state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CHANNELS-1:0]  resetn_q, resetn_d;
    logic                 fault_seen_q, fault_seen_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [StagW-1:0]     stag_q, stag_d;
    logic                 fault_meta_q, fault_s_q;

    logic                 nxt_found;
    logic                 nxt_more;
    logic [IdxW-1:0]      nxt_idx;

    // Lowest enabled channel still to release; nxt_more flags another enabled one above it.
    always_comb begin
        nxt_found = 1'b0;
        nxt_more  = 1'b0;
        nxt_idx   = '0;
        for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
            if (bus.chan_en[i] && (state_q == StStretch || i > int'(idx_q))) begin
                if (nxt_found) nxt_more = 1'b1;
                nxt_found = 1'b1;
                nxt_idx   = IdxW'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        resetn_d     = resetn_q;
        fault_seen_d = fault_seen_q;
        idx_d        = idx_q;
        stag_d       = stag_q;

        if (!bus.rstb_req) begin
            state_d  = StIdle;
            count_d  = '0;
            resetn_d = '0;
            idx_d    = '0;
            stag_d   = '0;
        end else if (fault_s_q && state_q != StIdle) begin
            // Held at count 0 for as long as the fault persists.
            state_d      = StStretch;
            count_d      = '0;
            resetn_d     = '0;
            fault_seen_d = 1'b1;
            idx_d        = '0;
            stag_d       = '0;
        end else if (bus.sw_reset && state_q != StIdle) begin
            state_d      = StStretch;
            count_d      = '0;
            resetn_d     = '0;
            fault_seen_d = 1'b0;
            idx_d        = '0;
            stag_d       = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StStretch;
                    count_d = '0;
                end
                StStretch: begin
                    if (count_q == '1) begin
                        stag_d = '0;
                        if (nxt_found) begin
                            resetn_d[nxt_idx] = 1'b1;
                            idx_d             = nxt_idx;
                            state_d           = nxt_more ? StRelease : StRun;
                        end else begin
                            state_d = StRun;
                        end
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                StRelease: begin
                    if (stag_q == StagW'(STAGGER - 1)) begin
                        stag_d = '0;
                        if (nxt_found) begin
                            resetn_d[nxt_idx] = 1'b1;
                            idx_d             = nxt_idx;
                            state_d           = nxt_more ? StRelease : StRun;
                        end else begin
                            state_d = StRun;
                        end
                    end else begin
                        stag_d = stag_q + 1'b1;
                    end
                end
                StRun: begin
                    // Masking can only pull a channel back into reset, never release it.
                    resetn_d = resetn_q & bus.chan_en;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= StIdle;
            count_q      <= '0;
            resetn_q     <= '0;
            fault_seen_q <= 1'b0;
            idx_q        <= '0;
            stag_q       <= '0;
            fault_meta_q <= 1'b0;
            fault_s_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            resetn_q     <= resetn_d;
            fault_seen_q <= fault_seen_d;
            idx_q        <= idx_d;
            stag_q       <= stag_d;
            fault_meta_q <= bus.fault_i;
            fault_s_q    <= fault_meta_q;
        end
    end

    assign bus.resetn_o   = resetn_q;
    assign bus.count_o    = count_q;
    assign bus.fault_seen = fault_seen_q;
    assign bus.busy       = (state_q == StStretch) || (state_q == StRelease);
    assign bus.done       = (state_q == StRun);

endmodule
